// File: rtl/in_port_switch_pkg.sv
// Shared router constants: output port indices and port count.
package in_port_switch_pkg;

  localparam int unsigned NUM_PORTS  = 5;
  localparam int unsigned PORT_IDX_W = 3;

  localparam int unsigned NORTH = 0;
  localparam int unsigned EAST  = 1;
  localparam int unsigned SOUTH = 2;
  localparam int unsigned WEST  = 3;
  localparam int unsigned LOCAL = 4;

  typedef logic [PORT_IDX_W-1:0] port_idx_t;

endpackage

// File: rtl/in_port_switch_sync_fifo.sv
// Synchronous FIFO (sync_fifo role) buffering incoming flits ahead of routing.
// Ports:
//   clk, rst        - clock, synchronous active-high reset
//   push, wdata     - write request and data (ignored when full)
//   pop             - remove head entry (ignored when empty)
//   rdata           - head entry, valid while empty=0
//   count           - number of stored entries, 0..DEPTH
//   full, empty     - occupancy flags
module in_port_switch_sync_fifo #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign rdata   = mem[rd_ptr];

  // Storage array, no reset needed: entries are only read once written.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= wdata;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/in_port_switch.sv
// Router input port: buffers flits in a FIFO, XY-routes the head flit and
// loads it into one of five output registers when that port is free.
// Ports:
//   clk, rst    - clock, synchronous active-high reset
//   data_in     - flit {dest_x, dest_y, payload}, dest_x in the MSBs
//   data_valid  - data_in valid this cycle
//   port_busy   - FIFO full; a flit offered now is dropped
//   port_out    - five output registers, slice i at [i*DATA_WIDTH +: DATA_WIDTH]
//   port_valid  - bit i set while slice i holds an unconsumed flit
//   clear       - bit i set when the consumer takes port i this cycle
module in_port_switch
  import in_port_switch_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned FIFO_DEPTH = 16,
  parameter int unsigned POS_WIDTH  = 4,
  parameter int unsigned POS_X      = 0,
  parameter int unsigned POS_Y      = 0
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [DATA_WIDTH-1:0]           data_in,
  input  logic                            data_valid,
  output logic                            port_busy,
  output logic [NUM_PORTS*DATA_WIDTH-1:0] port_out,
  output logic [NUM_PORTS-1:0]            port_valid,
  input  logic [NUM_PORTS-1:0]            clear
);

  localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

  logic [DATA_WIDTH-1:0] head;
  logic [CW-1:0]         count;
  logic                  full;
  logic                  empty;
  logic                  pop;
  logic [POS_WIDTH-1:0]  dest_x;
  logic [POS_WIDTH-1:0]  dest_y;
  port_idx_t             route;
  logic                  route_free;

  assign port_busy = (count == CW'(FIFO_DEPTH));

  in_port_switch_sync_fifo #(
    .WIDTH (DATA_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (data_valid & ~full),
    .wdata (data_in),
    .pop   (pop),
    .rdata (head),
    .count (count),
    .full  (full),
    .empty (empty)
  );

  assign dest_x = head[DATA_WIDTH-1 -: POS_WIDTH];
  assign dest_y = head[DATA_WIDTH-POS_WIDTH-1 -: POS_WIDTH];

  // Dimension-order routing: resolve X first, then Y, else deliver locally.
  always_comb begin
    route = port_idx_t'(LOCAL);
    if (dest_x > POS_WIDTH'(POS_X)) begin
      route = port_idx_t'(EAST);
    end else if (dest_x < POS_WIDTH'(POS_X)) begin
      route = port_idx_t'(WEST);
    end else if (dest_y < POS_WIDTH'(POS_Y)) begin
      route = port_idx_t'(NORTH);
    end else if (dest_y > POS_WIDTH'(POS_Y)) begin
      route = port_idx_t'(SOUTH);
    end
  end

  // A port being consumed this cycle can accept the next flit on the same edge.
  assign route_free = ~port_valid[route] | clear[route];
  assign pop        = ~empty & route_free;

  // Output registers: a load takes priority over a clear on the same port.
  always_ff @(posedge clk) begin
    if (rst) begin
      port_valid <= '0;
      port_out   <= '0;
    end else begin
      for (int i = 0; i < NUM_PORTS; i++) begin
        if (pop && (route == port_idx_t'(i))) begin
          port_valid[i]                           <= 1'b1;
          port_out[i*DATA_WIDTH +: DATA_WIDTH]    <= head;
        end else if (clear[i]) begin
          port_valid[i] <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_in_port_switch.sv
// Self-checking bench for in_port_switch: directed scenarios then random
// traffic, compared against a queue-based reference model every cycle.
module tb_in_port_switch;

  localparam int unsigned DW    = 16;
  localparam int unsigned PW    = 4;
  localparam int unsigned DEPTH = 8;
  localparam int unsigned NP    = 5;

  logic            clk = 1'b0;
  logic            rst;
  logic [DW-1:0]   data_in;
  logic            data_valid;
  logic            port_busy;
  logic [NP*DW-1:0] port_out;
  logic [NP-1:0]   port_valid;
  logic [NP-1:0]   clear;

  int total = 0;
  int bad   = 0;

  // Reference model state
  logic [DW-1:0] mq [$];
  logic [DW-1:0] m_out [NP];
  logic [NP-1:0] m_val;

  in_port_switch #(
    .DATA_WIDTH (DW),
    .FIFO_DEPTH (DEPTH),
    .POS_WIDTH  (PW),
    .POS_X      (1),
    .POS_Y      (1)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .data_in    (data_in),
    .data_valid (data_valid),
    .port_busy  (port_busy),
    .port_out   (port_out),
    .port_valid (port_valid),
    .clear      (clear)
  );

  always #5 clk = ~clk;

  // XY destination port for a router at (1,1): 0=N 1=E 2=S 3=W 4=L
  function automatic int dest_port(input logic [DW-1:0] f);
    int unsigned x;
    int unsigned y;
    x = int'(f[15:12]);
    y = int'(f[11:8]);
    if (x > 1) return 1;
    if (x < 1) return 3;
    if (y < 1) return 0;
    if (y > 1) return 2;
    return 4;
  endfunction

  task automatic check(input string tag, input logic [79:0] obs, input logic [79:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: drive inputs, check busy, advance model and DUT, check outputs.
  task automatic cycle(input logic dv, input logic [DW-1:0] d, input logic [NP-1:0] clr);
    int r;
    logic busy;
    logic [NP*DW-1:0] exp_out;
    data_valid = dv;
    data_in    = d;
    clear      = clr;
    #1;
    busy = (mq.size() == DEPTH);
    if (!rst) check("busy", 80'(port_busy), 80'(busy));
    @(posedge clk);
    if (rst) begin
      mq.delete();
      m_val = '0;
      for (int i = 0; i < NP; i++) m_out[i] = '0;
    end else begin
      r = -1;
      if (mq.size() > 0) begin
        r = dest_port(mq[0]);
        if (!m_val[r] || clr[r]) begin
          m_val[r] = 1'b1;
          m_out[r] = mq.pop_front();
        end else begin
          r = -1;
        end
      end
      for (int i = 0; i < NP; i++) begin
        if (clr[i] && i != r) m_val[i] = 1'b0;
      end
      if (dv && !busy) mq.push_back(d);
    end
    #1;
    for (int i = 0; i < NP; i++) exp_out[i*DW +: DW] = m_out[i];
    check("port_valid", 80'(port_valid), 80'(m_val));
    check("port_out", 80'(port_out), 80'(exp_out));
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) cycle(1'b0, '0, '0);
  endtask

  initial begin
    logic [DW-1:0] f;
    logic [NP-1:0] c;
    rst        = 1'b1;
    data_valid = 1'b0;
    data_in    = '0;
    clear      = '0;
    @(negedge clk);
    cycle(1'b1, 16'h1101, 5'h1f);
    cycle(1'b0, '0, '0);
    rst = 1'b0;

    // Reset state
    #1;
    check("rst_valid", 80'(port_valid), 80'(5'b00000));
    check("rst_busy", 80'(port_busy), 80'(1'b0));
    check("rst_out", 80'(port_out), 80'(0));

    // Routing: one flit per destination, back to back
    cycle(1'b1, 16'h0001, '0);
    cycle(1'b1, 16'h1001, '0);
    cycle(1'b1, 16'h1201, '0);
    cycle(1'b1, 16'h2201, '0);
    cycle(1'b1, 16'h1101, '0);
    idle(1);
    check("route_valid", 80'(port_valid), 80'(5'b11111));
    check("route_out", 80'(port_out),
          80'({16'h1101, 16'h0001, 16'h1201, 16'h2201, 16'h1001}));

    // Blocking: all ports occupied, new flits must wait
    cycle(1'b1, 16'h0002, '0);
    cycle(1'b1, 16'h1002, '0);
    cycle(1'b1, 16'h1202, '0);
    cycle(1'b1, 16'h2202, '0);
    cycle(1'b1, 16'h1102, '0);
    idle(2);
    check("block_valid", 80'(port_valid), 80'(5'b11111));
    check("block_out", 80'(port_out),
          80'({16'h1101, 16'h0001, 16'h1201, 16'h2201, 16'h1001}));
    cycle(1'b0, '0, 5'b11111);
    idle(5);
    check("reload_valid", 80'(port_valid), 80'(5'b11111));
    check("reload_out", 80'(port_out),
          80'({16'h1102, 16'h0002, 16'h1202, 16'h2202, 16'h1002}));
    cycle(1'b0, '0, port_valid);
    check("drain_valid", 80'(port_valid), 80'(5'b00000));

    // Head-of-line blocking, then clear/load collision on west
    cycle(1'b1, 16'h0003, '0);
    idle(1);
    cycle(1'b1, 16'h0004, '0);
    cycle(1'b1, 16'h2004, '0);
    idle(3);
    check("hol_valid", 80'(port_valid), 80'(5'b01000));
    cycle(1'b0, '0, 5'b01000);
    check("collide_valid", 80'(port_valid), 80'(5'b01000));
    check("collide_west", 80'(port_out[3*DW +: DW]), 80'(16'h0004));
    idle(1);
    check("hol_release", 80'(port_valid), 80'(5'b01010));
    check("hol_east", 80'(port_out[1*DW +: DW]), 80'(16'h2004));
    cycle(1'b0, '0, 5'b11111);

    // Full: all ports occupied, push DEPTH+1 flits
    cycle(1'b1, 16'h0005, '0);
    cycle(1'b1, 16'h1005, '0);
    cycle(1'b1, 16'h1205, '0);
    cycle(1'b1, 16'h2205, '0);
    cycle(1'b1, 16'h1105, '0);
    idle(1);
    for (int k = 0; k < DEPTH; k++) cycle(1'b1, 16'h0010 + 16'(k), '0);
    check("full_busy", 80'(port_busy), 80'(1'b1));
    cycle(1'b1, 16'h00ee, '0);
    check("full_still", 80'(port_busy), 80'(1'b1));
    for (int k = 0; k < DEPTH + 2; k++) cycle(1'b0, '0, 5'b01000);
    check("full_last", 80'(port_out[3*DW +: DW]), 80'(16'h0017));
    check("full_empty", 80'(port_busy), 80'(1'b0));
    cycle(1'b0, '0, 5'b11111);

    // Random traffic
    for (int k = 0; k < 400; k++) begin
      f = {4'($urandom_range(0, 2)), 4'($urandom_range(0, 2)), 8'($urandom)};
      c = 5'($urandom) & 5'($urandom);
      cycle(1'($urandom), f, c);
    end

    // Reset mid-operation discards everything
    for (int k = 0; k < 6; k++) cycle(1'b1, 16'h0021, '0);
    rst = 1'b1;
    cycle(1'b1, 16'h2222, '0);
    rst = 1'b0;
    #1;
    check("midrst_valid", 80'(port_valid), 80'(5'b00000));
    check("midrst_busy", 80'(port_busy), 80'(1'b0));
    check("midrst_out", 80'(port_out), 80'(0));
    idle(3);
    check("midrst_idle", 80'(port_valid), 80'(5'b00000));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
